spi_reg_bank: RTL and testbench



---
 rtl/spi_reg_bank.sv | 122 ++++++++++++
 tb/tb_spi_reg_bank.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: register bank behind the SPI slave (ID, LOCK, STATUS, general RW), optional write lock via SPI_REG_LOCK_EN
//   i_master_clock/i_rst  : clock, async active-high reset
//   i_spi_write/i_spi_read: one-cycle strobes with i_spi_addr (and i_spi_data for writes)
//   o_data_word_send      : read return word, valid with o_rd_valid pulse, held until next read
//   o_wr_strobe           : one-hot pulse per committed write
//   o_regs                : flat register image, offset k at [k*WORD_LEN +: WORD_LEN]
//   o_err                 : one-cycle pulse per counted protocol error
module spi_reg_bank #(
  parameter int ADDR_LEN = 8,
  parameter int WORD_LEN = 16,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR = 8'h78,
  parameter int NUM_REGS = 16,
  parameter logic [WORD_LEN-1:0] ID_VALUE = 16'h5A01,
  parameter logic [WORD_LEN-1:0] OOR_VALUE = 16'hDEAD
) (
  input  logic                         i_master_clock,
  input  logic                         i_rst,
  input  logic                         i_spi_write,
  input  logic                         i_spi_read,
  input  logic [ADDR_LEN-1:0]          i_spi_addr,
  input  logic [WORD_LEN-1:0]          i_spi_data,
  output logic [WORD_LEN-1:0]          o_data_word_send,
  output logic                         o_rd_valid,
  output logic [NUM_REGS-1:0]          o_wr_strobe,
  output logic [NUM_REGS*WORD_LEN-1:0] o_regs,
  output logic                         o_err
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [ADDR_LEN:0] LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_LEN:0] HI = (ADDR_LEN+1)'(int'(BASE_ADDR) + NUM_REGS);
  typedef enum logic {IDLE, RD_FETCH} state_e;
  state_e state_q, state_d;
  logic [WORD_LEN-1:0] regs_q [NUM_REGS];
  logic [WORD_LEN-1:0] regs_d [NUM_REGS];
  logic [IW-1:0] rd_idx_q, rd_idx_d, idx;
  logic rd_oor_q, rd_oor_d, rd_valid_q, rd_valid_d, err_q, err_d;
  logic [WORD_LEN-1:0] data_q, data_d, status;
  logic [NUM_REGS-1:0] wr_strobe_q, wr_strobe_d;
  logic [7:0] err_cnt_q, err_cnt_d, wr_cnt_q, wr_cnt_d;
  logic in_rng, locked, clr, commit;
  assign idx = IW'(i_spi_addr - BASE_ADDR);
  assign in_rng = ({1'b0, i_spi_addr} >= LO) && ({1'b0, i_spi_addr} < HI);
  assign status = WORD_LEN'({err_cnt_q, wr_cnt_q});
`ifdef SPI_REG_LOCK_EN
  assign locked = (idx >= IW'(3)) && (regs_q[1] != WORD_LEN'(16'hA5A5));
`else
  assign locked = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    regs_d = regs_q;
    rd_idx_d = rd_idx_q;
    rd_oor_d = rd_oor_q;
    data_d = data_q;
    rd_valid_d = 1'b0;
    wr_strobe_d = '0;
    err_d = 1'b0;
    clr = 1'b0;
    commit = 1'b0;
    if (state_q == RD_FETCH) begin
      data_d = rd_oor_q ? OOR_VALUE : rd_idx_q == '0 ? ID_VALUE : rd_idx_q == IW'(2) ? status : regs_q[rd_idx_q];
      rd_valid_d = 1'b1;
      err_d = i_spi_write | i_spi_read;
      state_d = IDLE;
    end else if (i_spi_write && i_spi_read) begin
      err_d = 1'b1;
    end else if (i_spi_read) begin
      rd_idx_d = idx;
      rd_oor_d = !in_rng;
      err_d = !in_rng;
      state_d = RD_FETCH;
    end else if (i_spi_write) begin
      err_d = !in_rng || locked;
      clr = in_rng && idx == IW'(2);
      commit = in_rng && !locked && idx != '0 && idx != IW'(2);
      if (commit) begin
        regs_d[idx] = i_spi_data;
        wr_strobe_d[idx] = 1'b1;
      end
    end
    err_cnt_d = clr ? 8'h00 : (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'h01 : err_cnt_q;
    wr_cnt_d = clr ? 8'h00 : commit ? wr_cnt_q + 8'h01 : wr_cnt_q;
  end
  always_ff @(posedge i_master_clock or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      regs_q <= '{default: '0};
      rd_idx_q <= '0;
      rd_oor_q <= 1'b0;
      data_q <= '0;
      rd_valid_q <= 1'b0;
      wr_strobe_q <= '0;
      err_q <= 1'b0;
      err_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      regs_q <= regs_d;
      rd_idx_q <= rd_idx_d;
      rd_oor_q <= rd_oor_d;
      data_q <= data_d;
      rd_valid_q <= rd_valid_d;
      wr_strobe_q <= wr_strobe_d;
      err_q <= err_d;
      err_cnt_q <= err_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_img
    if (k == 0) begin : g_id
      assign o_regs[k*WORD_LEN +: WORD_LEN] = ID_VALUE;
    end else if (k == 2) begin : g_st
      assign o_regs[k*WORD_LEN +: WORD_LEN] = status;
    end else begin : g_rw
      assign o_regs[k*WORD_LEN +: WORD_LEN] = regs_q[k];
    end
  end
  assign o_data_word_send = data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_wr_strobe = wr_strobe_q;
  assign o_err = err_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed and random checks of spi_reg_bank against a register-map model
module tb_spi_reg_bank;
  logic clk = 1'b0, rst = 1'b1, w = 1'b0, r = 1'b0;
  logic [7:0] addr = '0;
  logic [15:0] wdata = '0, o_data;
  logic o_rd_valid, o_err;
  logic [15:0] o_wr_strobe;
  logic [255:0] o_regs;
  logic [15:0] m [16];
  int ec = 0, wc = 0, total = 0, bad = 0;
`ifdef SPI_REG_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  spi_reg_bank dut (
    .i_master_clock(clk), .i_rst(rst), .i_spi_write(w), .i_spi_read(r),
    .i_spi_addr(addr), .i_spi_data(wdata), .o_data_word_send(o_data),
    .o_rd_valid(o_rd_valid), .o_wr_strobe(o_wr_strobe), .o_regs(o_regs), .o_err(o_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] mword(input int o);
    return o == 0 ? 16'h5A01 : o == 2 ? {ec[7:0], wc[7:0]} : m[o];
  endfunction
  function automatic logic [255:0] mimg();
    logic [255:0] v;
    for (int k = 0; k < 16; k++) v[k*16 +: 16] = mword(k);
    return v;
  endfunction
  function automatic void merr();
    if (ec < 255) ec++;
  endfunction
  function automatic void mreset();
    for (int k = 0; k < 16; k++) m[k] = '0;
    ec = 0;
    wc = 0;
  endfunction
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    int o;
    logic e;
    logic [15:0] s;
    o = int'(a) - 'h78;
    e = 1'b0;
    s = '0;
    if (o < 0 || o > 15) e = 1'b1;
    else if (o == 2) begin ec = 0; wc = 0; end
    else if (o != 0) begin
      if (LOCK_EN && o >= 3 && m[1] != 16'hA5A5) e = 1'b1;
      else begin m[o] = d; wc = (wc + 1) % 256; s[o] = 1'b1; end
    end
    if (e) merr();
    w = 1'b1; addr = a; wdata = d;
    tick();
    w = 1'b0;
    chk("wr_strobe", 256'(o_wr_strobe), 256'(s));
    chk("wr_err", 256'(o_err), 256'(e));
    chk("wr_image", o_regs, mimg());
    tick();
    chk("wr_strobe_clear", 256'(o_wr_strobe), 256'(0));
  endtask
  task automatic rd(input logic [7:0] a);
    int o;
    logic [15:0] exp;
    o = int'(a) - 'h78;
    exp = (o < 0 || o > 15) ? 16'hDEAD : mword(o);
    if (o < 0 || o > 15) merr();
    r = 1'b1; addr = a;
    tick();
    r = 1'b0;
    chk("rd_err", 256'(o_err), 256'(o < 0 || o > 15));
    chk("rd_valid_early", 256'(o_rd_valid), 256'(0));
    tick();
    chk("rd_valid", 256'(o_rd_valid), 256'(1));
    chk("rd_data", 256'(o_data), 256'(exp));
    tick();
    chk("rd_valid_pulse", 256'(o_rd_valid), 256'(0));
    chk("rd_data_hold", 256'(o_data), 256'(exp));
    chk("rd_image", o_regs, mimg());
  endtask
  initial begin
    logic [15:0] exp;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", 256'(o_data), 256'(0));
    chk("reset_image", o_regs, 256'(16'h5A01));
    @(negedge clk) rst = 1'b0;
    tick();
    rd(8'h78);
    wr(8'h79, 16'hA5A5);
    wr(8'h7C, 16'h1234);
    chk("off4_value", 256'(o_regs[79:64]), 256'(16'h1234));
    rd(8'h7C);
    chk("wcount", 256'(o_regs[39:32]), 256'(2));
    wr(8'h88, 16'hFFFF);
    rd(8'h77);
    chk("ecount_two", 256'(o_regs[47:40]), 256'(2));
    exp = m[4];
    r = 1'b1; addr = 8'h7C;
    tick();
    r = 1'b0; w = 1'b1; wdata = 16'h9999;
    tick();
    w = 1'b0;
    merr();
    chk("drop_valid", 256'(o_rd_valid), 256'(1));
    chk("drop_data", 256'(o_data), 256'(exp));
    chk("drop_err", 256'(o_err), 256'(1));
    chk("drop_image", o_regs, mimg());
    tick();
    for (int i = 0; i < 300; i++) wr(8'h90, 16'h0001);
    chk("ecount_sat", 256'(o_regs[47:40]), 256'(8'hFF));
    wr(8'h7A, 16'h1357);
    rd(8'h7A);
    chk("status_cleared", 256'(o_data), 256'(0));
    w = 1'b1; r = 1'b1; addr = 8'h7D; wdata = 16'h4444;
    tick();
    w = 1'b0; r = 1'b0;
    merr();
    chk("both_err", 256'(o_err), 256'(1));
    chk("both_strobe", 256'(o_wr_strobe), 256'(0));
    tick();
    chk("both_no_read", 256'(o_rd_valid), 256'(0));
    chk("both_image", o_regs, mimg());
`ifdef SPI_REG_LOCK_EN
    wr(8'h79, 16'h0000);
    wr(8'h80, 16'hABCD);
    chk("locked_off8", 256'(o_regs[143:128]), 256'(0));
    wr(8'h79, 16'hA5A5);
    wr(8'h80, 16'hABCD);
    chk("unlocked_off8", 256'(o_regs[143:128]), 256'(16'hABCD));
`endif
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1) wr(8'h74 + 8'($urandom_range(0, 23)), 16'($urandom));
      else rd(8'h74 + 8'($urandom_range(0, 23)));
    end
    rd(8'h78);
    r = 1'b1; addr = 8'h78;
    tick();
    r = 1'b0;
    #2 rst = 1'b1;
    #1;
    mreset();
    chk("rst_data", 256'(o_data), 256'(0));
    chk("rst_image", o_regs, mimg());
    chk("rst_err", 256'(o_err), 256'(0));
    tick();
    chk("rst_no_valid", 256'(o_rd_valid), 256'(0));
    chk("rst_strobe", 256'(o_wr_strobe), 256'(0));
    @(negedge clk) rst = 1'b0;
    tick();
    rd(8'h7C);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
